// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: core port (fixed priority) and loader port share one
// single-port synchronous memory; a starve counter guarantees the loader a turn.
module dmem_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 9,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c_rd,
    input  logic              c_wr,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic [DATA_W-1:0] c_rdata,
    output logic              c_stall,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [DATA_W-1:0] l_rdata,
    output logic              m_rd,
    output logic              m_wr,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_CORE_ACC  = 3'd1;
    localparam logic [2:0] S_CORE_RESP = 3'd2;
    localparam logic [2:0] S_LOAD_ACC  = 3'd3;
    localparam logic [2:0] S_LOAD_RESP = 3'd4;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [2:0]        state_q, state_d;
    logic [3:0]        starve_q, starve_d;
    logic              m_rd_q, m_rd_d;
    logic              m_wr_q, m_wr_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;

    logic c_req;
    logic core_ack;
    logic core_wins;

    assign c_req     = c_rd | c_wr;
    assign core_wins = c_req & (~l_req | (starve_q < LIMIT));

    always_comb begin
        state_d   = state_q;
        starve_d  = starve_q;
        m_rd_d    = 1'b0;
        m_wr_d    = 1'b0;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        core_ack  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (core_wins) begin
                    // rd+wr together is a write
                    state_d   = S_CORE_ACC;
                    m_wr_d    = c_wr;
                    m_rd_d    = ~c_wr;
                    m_addr_d  = c_addr;
                    m_wdata_d = c_wdata;
                    if (l_req && (starve_q < LIMIT)) begin
                        starve_d = starve_q + 4'd1;
                    end
                end else if (l_req) begin
                    state_d   = S_LOAD_ACC;
                    m_wr_d    = l_we;
                    m_rd_d    = ~l_we;
                    m_addr_d  = l_addr;
                    m_wdata_d = l_wdata;
                    starve_d  = '0;
                end
            end
            S_CORE_ACC: begin
                // The registered write strobe remembers the access type
                core_ack = m_wr_q;
                state_d  = m_wr_q ? S_IDLE : S_CORE_RESP;
            end
            S_CORE_RESP: begin
                core_ack = 1'b1;
                state_d  = S_IDLE;
            end
            S_LOAD_ACC: begin
                state_d = m_wr_q ? S_IDLE : S_LOAD_RESP;
            end
            S_LOAD_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            starve_q  <= '0;
            m_rd_q    <= 1'b0;
            m_wr_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            m_rd_q    <= m_rd_d;
            m_wr_q    <= m_wr_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
        end
    end

    assign m_rd     = m_rd_q;
    assign m_wr     = m_wr_q;
    assign m_addr   = m_addr_q;
    assign m_wdata  = m_wdata_q;

    assign c_stall  = c_req & ~core_ack & reset;
    assign c_rdata  = (state_q == S_CORE_RESP) ? m_rdata : '0;
    assign l_gnt    = (state_q == S_LOAD_ACC);
    assign l_rvalid = (state_q == S_LOAD_RESP);
    assign l_rdata  = (state_q == S_LOAD_RESP) ? m_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vectors, reset corners,
// starvation sequence and random rounds against a transaction-order model.
module tb_dmem_arbiter;

    localparam int STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        c_rd, c_wr;
    logic [8:0]  c_addr;
    logic [31:0] c_wdata, c_rdata;
    logic        c_stall;
    logic        l_req, l_we;
    logic [8:0]  l_addr;
    logic [31:0] l_wdata, l_rdata;
    logic        l_gnt, l_rvalid;
    logic        m_rd, m_wr;
    logic [8:0]  m_addr;
    logic [31:0] m_wdata, m_rdata;

    int total = 0;
    int bad   = 0;

    dmem_arbiter #(
        .DATA_W      (32),
        .ADDR_W      (9),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .c_rd    (c_rd),
        .c_wr    (c_wr),
        .c_addr  (c_addr),
        .c_wdata (c_wdata),
        .c_rdata (c_rdata),
        .c_stall (c_stall),
        .l_req   (l_req),
        .l_we    (l_we),
        .l_addr  (l_addr),
        .l_wdata (l_wdata),
        .l_gnt   (l_gnt),
        .l_rvalid(l_rvalid),
        .l_rdata (l_rdata),
        .m_rd    (m_rd),
        .m_wr    (m_wr),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata)
    );

    always #5 clk = ~clk;

    // Single-port synchronous memory; preloaded on the first clock.
    bit          mem_init = 1'b0;
    logic [31:0] mem [512];
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 512; i++)
                mem[i] <= (i == 16) ? 32'hDEADBEEF : (32'hC0DE0000 | 32'(i));
            mem_init <= 1'b1;
        end else begin
            if (m_wr) mem[m_addr] <= m_wdata;
            if (m_rd) m_rdata <= mem[m_addr];
        end
    end

    logic [31:0] ref_mem [512];
    int          m_starve = 0;

    typedef struct {
        bit          ld;
        bit          rd;
        bit          wr;
        logic [8:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    typedef struct {
        bit          ld;
        bit          wr;
        bit          rdtoo;
        logic [8:0]  addr;
        logic [31:0] data;
    } ev_t;

    vec_t vecs [10];
    ev_t  cops [8];
    ev_t  lop;
    ev_t  exp_q [$];
    bit   obs_q [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int          strobes = 0;
        int          lat = 0;
        int          gnt_at = 0;
        bit          done = 1'b0;
        bit          sw = 1'b0;
        logic [8:0]  sa = '0;
        logic [31:0] sd = '0;
        logic [31:0] rd = '0;
        @(negedge clk);
        if (v.ld) begin
            l_req = 1'b1; l_we = v.wr; l_addr = v.addr; l_wdata = v.wdata;
        end else begin
            c_rd = v.rd; c_wr = v.wr; c_addr = v.addr; c_wdata = v.wdata;
        end
        for (int cyc = 1; cyc <= 12; cyc++) begin
            #1;
            if (m_rd || m_wr) begin
                strobes++; sa = m_addr; sd = m_wdata; sw = m_wr;
            end
            if (v.ld) begin
                if (l_gnt) gnt_at = cyc;
                if ((v.wr && l_gnt) || (!v.wr && l_rvalid)) begin
                    done = 1'b1; lat = cyc; rd = l_rdata;
                end
            end else if (!c_stall) begin
                done = 1'b1; lat = cyc; rd = c_rdata;
            end
            @(negedge clk);
            if (gnt_at > 0) l_req = 1'b0;
            if (done) break;
        end
        c_rd = 1'b0; c_wr = 1'b0; l_req = 1'b0;
        #1;
        chk($sformatf("v%0d_done", idx), 32'(done), 32'd1);
        chk($sformatf("v%0d_lat", idx), 32'(lat), 32'(v.exp_lat));
        chk($sformatf("v%0d_strobes", idx), 32'(strobes), 32'd1);
        chk($sformatf("v%0d_maddr", idx), 32'(sa), 32'(v.addr));
        chk($sformatf("v%0d_mwr", idx), 32'(sw), 32'(v.wr));
        if (v.wr) chk($sformatf("v%0d_mwdata", idx), sd, v.wdata);
        else      chk($sformatf("v%0d_rdata", idx), rd, v.exp_rdata);
        if (v.ld) chk($sformatf("v%0d_gnt_cycle", idx), 32'(gnt_at), 32'd2);
        chk($sformatf("v%0d_idle_rdata", idx), c_rdata | l_rdata, 32'h0);
        chk($sformatf("v%0d_idle_strobe", idx), 32'(m_rd | m_wr), 32'd0);
        if (v.wr) ref_mem[v.addr] = v.wdata;
    endtask

    task automatic drive_core(input ev_t e);
        c_rd = e.rdtoo | ~e.wr; c_wr = e.wr; c_addr = e.addr; c_wdata = e.data;
    endtask

    // Predict service order and data from the arbitration rules, then run it.
    task automatic run_round(input int ncore, input bit lreq, input int rnd);
        int  ci = 0;
        int  ei = 0;
        bit  lp = lreq;
        bit  rv_pend = 1'b0;
        bit  both_seen = 1'b0;
        bit  done = 1'b0;
        logic [31:0] rv_data = '0;
        ev_t e;
        exp_q.delete();
        obs_q.delete();
        while (ci < ncore || lp) begin
            if (ci < ncore && (!lp || m_starve < STARVE_LIMIT)) begin
                e = cops[ci];
                ci++;
                if (lp) m_starve++;
            end else begin
                e = lop;
                lp = 1'b0;
                m_starve = 0;
            end
            if (e.wr) ref_mem[e.addr] = e.data;
            else      e.data = ref_mem[e.addr];
            exp_q.push_back(e);
        end

        ci = 0;
        @(negedge clk);
        if (ncore > 0) drive_core(cops[0]);
        if (lreq) begin
            l_req = 1'b1; l_we = lop.wr; l_addr = lop.addr; l_wdata = lop.data;
        end
        for (int cyc = 0; cyc < 200; cyc++) begin
            bit cack;
            bit gnt;
            #1;
            if (m_rd && m_wr) both_seen = 1'b1;
            cack = (c_rd | c_wr) & ~c_stall;
            gnt  = l_gnt;
            if (cack) begin
                obs_q.push_back(1'b0);
                if (ei < exp_q.size()) begin
                    chk($sformatf("r%0d_src%0d", rnd, ei), 32'd0, 32'(exp_q[ei].ld));
                    if (!exp_q[ei].wr)
                        chk($sformatf("r%0d_crdata%0d", rnd, ei), c_rdata, exp_q[ei].data);
                end else chk($sformatf("r%0d_extra_ack", rnd), 32'(ei), 32'(exp_q.size() - 1));
                ei++;
            end
            if (gnt) begin
                obs_q.push_back(1'b1);
                if (ei < exp_q.size()) begin
                    chk($sformatf("r%0d_src%0d", rnd, ei), 32'd1, 32'(exp_q[ei].ld));
                    chk($sformatf("r%0d_gnt_addr", rnd), 32'(m_addr), 32'(lop.addr));
                    if (!exp_q[ei].wr) begin
                        rv_pend = 1'b1; rv_data = exp_q[ei].data;
                    end
                end else chk($sformatf("r%0d_extra_gnt", rnd), 32'(ei), 32'(exp_q.size() - 1));
                ei++;
            end
            if (l_rvalid) begin
                chk($sformatf("r%0d_rvalid_expected", rnd), 32'(rv_pend), 32'd1);
                chk($sformatf("r%0d_lrdata", rnd), l_rdata, rv_data);
                rv_pend = 1'b0;
            end
            @(negedge clk);
            if (cack) begin
                ci++;
                if (ci < ncore) drive_core(cops[ci]);
                else begin c_rd = 1'b0; c_wr = 1'b0; end
            end
            if (gnt) l_req = 1'b0;
            if (ei >= exp_q.size() && !rv_pend) begin
                done = 1'b1;
                break;
            end
        end
        c_rd = 1'b0; c_wr = 1'b0; l_req = 1'b0;
        chk($sformatf("r%0d_done", rnd), 32'(done), 32'd1);
        chk($sformatf("r%0d_strobe_excl", rnd), 32'(both_seen), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int p;
        for (int i = 0; i < 512; i++)
            ref_mem[i] = (i == 16) ? 32'hDEADBEEF : (32'hC0DE0000 | 32'(i));

        vecs[0] = '{0, 1, 0, 9'h010, 32'h0,        32'hDEADBEEF, 3};
        vecs[1] = '{0, 0, 1, 9'h1FF, 32'h12345678, 32'h0,        2};
        vecs[2] = '{0, 1, 0, 9'h1FF, 32'h0,        32'h12345678, 3};
        vecs[3] = '{1, 1, 0, 9'h003, 32'h0,        32'hC0DE0003, 3};
        vecs[4] = '{1, 0, 1, 9'h020, 32'hCAFEF00D, 32'h0,        2};
        vecs[5] = '{0, 1, 0, 9'h020, 32'h0,        32'hCAFEF00D, 3};
        vecs[6] = '{0, 1, 1, 9'h005, 32'h55AA55AA, 32'h0,        2};
        vecs[7] = '{1, 1, 0, 9'h005, 32'h0,        32'h55AA55AA, 3};
        vecs[8] = '{1, 1, 0, 9'h0AA, 32'h0,        32'h0BADF00D, 3};
        vecs[9] = '{0, 1, 0, 9'h000, 32'h0,        32'hC0DE0000, 3};

        // Reset values with both requesters active
        reset = 1'b0;
        c_rd = 1'b1; c_wr = 1'b0; c_addr = 9'h010; c_wdata = '0;
        l_req = 1'b1; l_we = 1'b0; l_addr = 9'h003; l_wdata = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_m_rd", 32'(m_rd), 32'd0);
        chk("rst_m_wr", 32'(m_wr), 32'd0);
        chk("rst_m_addr", 32'(m_addr), 32'd0);
        chk("rst_m_wdata", m_wdata, 32'd0);
        chk("rst_l_gnt", 32'(l_gnt), 32'd0);
        chk("rst_l_rvalid", 32'(l_rvalid), 32'd0);
        chk("rst_c_rdata", c_rdata, 32'd0);
        chk("rst_l_rdata", l_rdata, 32'd0);
        chk("rst_c_stall", 32'(c_stall), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1 chk("rel_stall", 32'(c_stall), 32'd1);
        @(negedge clk);
        #1;
        chk("rel_core_mrd", 32'(m_rd), 32'd1);
        chk("rel_core_maddr", 32'(m_addr), 32'h010);
        chk("rel_no_gnt", 32'(l_gnt), 32'd0);
        @(negedge clk);
        #1;
        chk("rel_ack_stall", 32'(c_stall), 32'd0);
        chk("rel_ack_rdata", c_rdata, 32'hDEADBEEF);
        @(negedge clk);
        c_rd = 1'b0;
        p = 0;
        for (int k = 1; k <= 5; k++) begin
            #1;
            if (l_gnt) begin p = k; break; end
            @(negedge clk);
        end
        chk("rel_ld_gnt", 32'(p), 32'd2);
        @(negedge clk);
        l_req = 1'b0;
        #1;
        chk("rel_ld_rvalid", 32'(l_rvalid), 32'd1);
        chk("rel_ld_rdata", l_rdata, 32'hC0DE0003);
        m_starve = 0;

        // Reset during the access cycle of a core write
        @(negedge clk);
        c_wr = 1'b1; c_addr = 9'h0AA; c_wdata = 32'h0BADF00D;
        #1 chk("mid_req_stall", 32'(c_stall), 32'd1);
        @(negedge clk);
        #1 chk("mid_acc_mwr", 32'(m_wr), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_mwr_drop", 32'(m_wr), 32'd0);
        chk("mid_rst_stall", 32'(c_stall), 32'd0);
        chk("mid_rst_maddr", 32'(m_addr), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        m_starve = 0;
        #1 chk("mid_rel_no_ack", 32'(c_stall), 32'd1);
        @(negedge clk);
        #1;
        chk("mid_reserve_mwr", 32'(m_wr), 32'd1);
        chk("mid_reserve_maddr", 32'(m_addr), 32'h0AA);
        chk("mid_reserve_ack", 32'(c_stall), 32'd0);
        @(negedge clk);
        c_wr = 1'b0;
        ref_mem[9'h0AA] = 32'h0BADF00D;

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // Starvation: six back-to-back core reads against a held loader read
        for (int i = 0; i < 6; i++) cops[i] = '{0, 0, 0, 9'(i + 8), 32'h0};
        lop = '{1, 0, 0, 9'h1F0, 32'h0};
        run_round(6, 1'b1, 999);
        p = -1;
        for (int i = 0; i < obs_q.size(); i++)
            if (obs_q[i] && p < 0) p = i;
        chk("starve_events", 32'(obs_q.size()), 32'd7);
        chk("starve_core_grants_first", 32'(p), 32'd4);
        if (obs_q.size() > 5) chk("starve_core_next", 32'(obs_q[5]), 32'd0);
        else                  chk("starve_core_next_missing", 32'(obs_q.size()), 32'd6);

        for (int r = 0; r < 40; r++) begin
            int ncore;
            bit lreq;
            ncore = $urandom_range(0, 6);
            lreq  = 1'($urandom_range(0, 1));
            if (ncore == 0) lreq = 1'b1;
            for (int i = 0; i < ncore; i++) begin
                int kind;
                kind = $urandom_range(0, 2);
                cops[i].ld    = 1'b0;
                cops[i].wr    = (kind != 0);
                cops[i].rdtoo = (kind == 2);
                cops[i].addr  = 9'($urandom_range(0, 15));
                cops[i].data  = $urandom;
            end
            lop.ld    = 1'b1;
            lop.wr    = 1'($urandom_range(0, 1));
            lop.rdtoo = 1'b0;
            lop.addr  = 9'($urandom_range(0, 15));
            lop.data  = $urandom;
            run_round(ncore, lreq, r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Sits between the core datapath's data-memory port (rd/wr/addr/wr_data/rd_data) and the single-port synchronous data memory.
- Shares that memory with a second requester: a debug/program loader port.
- Sequences each access as a multi-cycle transaction and stalls the core until its access completes.
- Fixed priority goes to the core; an anti-starvation counter guarantees the loader a turn.

Parameters:
DATA_W, 32, data word width
ADDR_W, 9, word address width
STARVE_LIMIT, 4, consecutive core wins over a pending loader request before the loader is forced a grant (1..15)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
c_rd  input  1  core read request, held until ack
c_wr  input  1  core write request, held until ack
c_addr  input  ADDR_W  core word address
c_wdata  input  DATA_W  core write data
c_rdata  output  DATA_W  core read data, valid in ack cycle of a read
c_stall  output  1  core must freeze and hold request
l_req  input  1  loader request, held until l_gnt
l_we  input  1  loader write (1) / read (0), valid with l_req
l_addr  input  ADDR_W  loader word address
l_wdata  input  DATA_W  loader write data
l_gnt  output  1  one-cycle pulse: loader access accepted
l_rvalid  output  1  one-cycle pulse: l_rdata valid
l_rdata  output  DATA_W  loader read data
m_rd  output  1  memory read strobe
m_wr  output  1  memory write strobe
m_addr  output  ADDR_W  memory address
m_wdata  output  DATA_W  memory write data
m_rdata  input  DATA_W  memory read data, valid cycle after m_rd

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, starve counter=0.
- Reset values of outputs: m_rd=0, m_wr=0, m_addr=0, m_wdata=0, l_gnt=0, l_rvalid=0, c_rstate 0, c_rdata=0, l_rdata=0, c_stall=0.
- Reset mid-transaction aborts it; any in-flight m_wr drops immediately; no ack or gnt is issued afterwards.
- States: IDLE, CORE_ACC, CORE_RESP, LOAD_ACC, LOAD_RESP. m_rd, m_wr, m_addr and m_wdata are registered, loaded on entry to the ACC states.
- Core request: c_req = c_rd | c_wr. If both c_rd and c_wr are high, the access is treated as a write.
- IDLE arbitration:
  - c_req only -> CORE_ACC.
  - l_req only -> LOAD_ACC.
  - Both requesting -> CORE_ACC if counter < STARVE_LIMIT, else LOAD_ACC.
  - Neither -> stay in IDLE.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) when the core wins while l_req=1.
  - Clears when the loader is granted.
  - Unchanged otherwise.
- CORE_ACC:
  - m_rd or m_wr = 1, with m_addr=c_addr and m_wdata=c_wdata as captured at the IDLE decision.
  - Write: the core ack is asserted in this cycle; next state IDLE.
  - Read: next state CORE_RESP.
- CORE_RESP: c_rdata=m_rdata and core ack=1; next state IDLE.
- c_stall = c_req & ~core_ack & reset, combinational.
  - Read: c_stall is high in the request cycle and in CORE_ACC, low in CORE_RESP.
  - Write: c_stall is high in the request cycle only.
- Latency: core write 2 cycles, core read 3 cycles (request to ack inclusive). There is no back-to-back pipelining; every transaction returns through IDLE.
- LOAD_ACC:
  - Drives m_* from the loader inputs; l_gnt=1 for exactly this cycle.
  - Write: next state IDLE.
  - Read: next state LOAD_RESP.
- LOAD_RESP: l_rvalid=1 and l_rdata=m_rdata; next state IDLE.
- Outside CORE_RESP, c_rdata=0. Outside LOAD_RESP, l_rdata=0.
- Request changes while not granted are permitted; only the values present in the IDLE decision cycle are used.
- Addresses pass through unmodified; ADDR_W wrap is the memory's concern. No address checking.
- m_rd and m_wr are never high simultaneously. Neither strobe is high in IDLE or in either RESP state.

Test Plan:
- Reset values: reset=0 with c_rd=1 and l_req=1 -> all outputs 0 and c_stall=0. Release reset -> core wins, m_rd=1 at the next edge.
- Core read: c_rd=1, c_addr=9'h010, memory returns 32'hDEADBEEF -> c_stall=1 for 2 cycles, then c_rdata=32'hDEADBEEF with c_stall=0 in cycle 3.
- Core write: c_wr=1, c_addr=9'h1FF, c_wdata=32'h12345678 -> one cycle with m_wr=1, m_addr=9'h1FF, m_wdata=32'h12345678. c_stall is high 1 cycle.
- Loader read: l_req=1, l_we=0, l_addr=9'h003 with the core idle -> l_gnt pulse 1 cycle, then l_rvalid pulse with l_rdata = memory word 3.
- Starvation: core back-to-back reads with l_req held, STARVE_LIMIT=4 -> exactly 4 core grants, then l_gnt. The counter clears, and the following core request is served next.
- Reset mid-operation: drop reset in CORE_ACC of a write -> m_wr falls without a clock edge, and no ack follows release. The core, still requesting, is re-served from IDLE.
